// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART: register offsets, STATUS bit
// positions, FSM encodings and the divisor floor.
`timescale 1ns/1ps
package uart_pkg;

  // Word offsets inside the 16-byte window (busAddress[3:2]).
  localparam logic [1:0] OFS_TXDATA  = 2'd0;
  localparam logic [1:0] OFS_RXDATA  = 2'd1;
  localparam logic [1:0] OFS_STATUS  = 2'd2;
  localparam logic [1:0] OFS_DIVISOR = 2'd3;

  // STATUS register bit positions.
  localparam int STAT_TX_FULL      = 0;
  localparam int STAT_TX_IDLE      = 1;
  localparam int STAT_RX_VALID     = 2;
  localparam int STAT_RX_OVERRUN   = 3;
  localparam int STAT_TX_OVERFLOW  = 4;
  localparam int STAT_RX_FRAME_ERR = 5;

  // Transmit FSM encoding.
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // Receive FSM encoding.
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Smallest usable bit period; the receiver needs divisor/2 >= 1.
  localparam logic [15:0] MIN_DIVISOR = 16'd2;

  // Clamp the programmed divisor to the usable range.
  function automatic logic [15:0] effDivisor(input logic [15:0] raw);
    return (raw < MIN_DIVISOR) ? MIN_DIVISOR : raw;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO. rdata always presents the oldest entry; a push
// while full or a pop while empty is ignored. Fullness is judged on the
// current occupancy, so a same-cycle pop does not make room for a push.
`timescale 1ns/1ps
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic doPush;
  logic doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdata  = mem[rdPtr[AW-1:0]];

  // Pointer update; wraps naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; pointers alone define validity, and leaving
  // it out lets the storage map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART slave: register decode, TX FIFO + serializer,
// RX synchronizer + deserializer with a one-byte holding register and
// write-1-to-clear sticky status.
`timescale 1ns/1ps
module bus_uart
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_F000,
  parameter logic [15:0] CLKS_PER_BIT = 16'd868,
  parameter int          TX_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] busAddress,
  input  logic [31:0] busDataIn,
  input  logic        busWriteEnable,
  output logic [31:0] busDataOut,
  output logic        selected,
  output logic        txd,
  input  logic        rxd
);

  // ---------------------------------------------------------------- decode
  logic [1:0] offset;
  logic       writeStrobe;
  logic       txPush;
  logic       statusWrite;
  logic       divisorWrite;
  logic       unusedBits;

  assign selected     = (busAddress[31:4] == BASE_ADDR[31:4]);
  assign offset       = busAddress[3:2];
  assign writeStrobe  = selected && busWriteEnable;
  assign txPush       = writeStrobe && (offset == OFS_TXDATA);
  assign statusWrite  = writeStrobe && (offset == OFS_STATUS);
  assign divisorWrite = writeStrobe && (offset == OFS_DIVISOR);
  assign unusedBits   = ^{busAddress[1:0], busDataIn[31:16]};

  // ---------------------------------------------------------------- divisor
  logic [15:0] divisor;

  // Raw DIVISOR register; clamping happens where a frame latches it.
  always_ff @(posedge clk) begin
    if (!reset)            divisor <= CLKS_PER_BIT;
    else if (divisorWrite) divisor <= busDataIn[15:0];
  end

  // ---------------------------------------------------------------- TX FIFO
  logic       fifoFull;
  logic       fifoEmpty;
  logic [7:0] fifoRdata;
  logic       txPop;

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) txFifo (
    .clk   (clk),
    .reset (reset),
    .push  (txPush),
    .pop   (txPop),
    .wdata (busDataIn[7:0]),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .rdata (fifoRdata)
  );

  // ---------------------------------------------------------------- TX FSM
  logic [1:0]  txState;
  logic [15:0] txCnt;
  logic [15:0] txDiv;
  logic [7:0]  txShift;
  logic [2:0]  txBit;
  logic        txLast;
  logic        txIdle;

  assign txLast = (txCnt == txDiv - 16'd1);
  // Pop from IDLE, or on the final STOP cycle so frames run back-to-back.
  assign txPop  = !fifoEmpty &&
                  ((txState == TX_IDLE) || ((txState == TX_STOP) && txLast));
  assign txIdle = fifoEmpty && (txState == TX_IDLE);

  // Serializer: txd is registered so every bit lasts exactly txDiv clocks.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      txState <= TX_IDLE;
      txCnt   <= '0;
      txDiv   <= MIN_DIVISOR;
      txShift <= '0;
      txBit   <= '0;
      txd     <= 1'b1;
    end else begin
      case (txState)
        TX_IDLE: begin
          if (txPop) begin
            txState <= TX_START;
            txShift <= fifoRdata;
            txDiv   <= effDivisor(divisor);
            txCnt   <= '0;
            txd     <= 1'b0;
          end
        end
        TX_START: begin
          if (txLast) begin
            txState <= TX_DATA;
            txCnt   <= '0;
            txBit   <= '0;
            txd     <= txShift[0];
            txShift <= txShift >> 1;
          end else begin
            txCnt <= txCnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (txLast) begin
            txCnt <= '0;
            if (txBit == 3'd7) begin
              txState <= TX_STOP;
              txd     <= 1'b1;
            end else begin
              txBit   <= txBit + 3'd1;
              txd     <= txShift[0];
              txShift <= txShift >> 1;
            end
          end else begin
            txCnt <= txCnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (txLast) begin
            txCnt <= '0;
            if (txPop) begin
              txState <= TX_START;
              txShift <= fifoRdata;
              txDiv   <= effDivisor(divisor);
              txd     <= 1'b0;
            end else begin
              txState <= TX_IDLE;
            end
          end else begin
            txCnt <= txCnt + 16'd1;
          end
        end
        default: txState <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX path
  logic        rxSync1;
  logic        rxSync2;
  logic        rxPrev;
  logic [1:0]  rxState;
  logic [15:0] rxCnt;
  logic [15:0] rxDiv;
  logic [7:0]  rxShift;
  logic [2:0]  rxBit;
  logic [7:0]  rxByte;
  logic        rxStopSample;
  logic        rxGoodStop;
  logic        rxBadStop;

  assign rxStopSample = (rxState == RX_STOP) && (rxCnt == rxDiv - 16'd1);
  assign rxGoodStop   = rxStopSample && rxSync2;
  assign rxBadStop    = rxStopSample && !rxSync2;

  // Synchronizer plus deserializer; samples land at mid-bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxSync1 <= 1'b1;
      rxSync2 <= 1'b1;
      rxPrev  <= 1'b1;
      rxState <= RX_IDLE;
      rxCnt   <= '0;
      rxDiv   <= MIN_DIVISOR;
      rxShift <= '0;
      rxBit   <= '0;
      rxByte  <= '0;
    end else begin
      rxSync1 <= rxd;
      rxSync2 <= rxSync1;
      rxPrev  <= rxSync2;
      case (rxState)
        RX_IDLE: begin
          if (rxPrev && !rxSync2) begin
            rxState <= RX_START;
            rxCnt   <= '0;
            rxDiv   <= effDivisor(divisor);
          end
        end
        RX_START: begin
          if (rxCnt == (rxDiv >> 1) - 16'd1) begin
            rxCnt   <= '0;
            rxBit   <= '0;
            // Still low at half a bit: genuine start; otherwise a glitch.
            rxState <= rxSync2 ? RX_IDLE : RX_DATA;
          end else begin
            rxCnt <= rxCnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (rxCnt == rxDiv - 16'd1) begin
            rxCnt   <= '0;
            rxShift <= {rxSync2, rxShift[7:1]};
            if (rxBit == 3'd7) rxState <= RX_STOP;
            else               rxBit   <= rxBit + 3'd1;
          end else begin
            rxCnt <= rxCnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (rxStopSample) begin
            rxCnt   <= '0;
            rxState <= RX_IDLE;
            if (rxGoodStop) rxByte <= rxShift;
          end else begin
            rxCnt <= rxCnt + 16'd1;
          end
        end
        default: rxState <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- status
  logic rxValid;
  logic rxOverrun;
  logic txOverflow;
  logic rxFrameErr;
  logic [5:0] clearMask;

  assign clearMask = statusWrite ? busDataIn[5:0] : 6'd0;

  // Sticky bits: a hardware set in the same cycle beats a write-1-to-clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxValid    <= 1'b0;
      rxOverrun  <= 1'b0;
      txOverflow <= 1'b0;
      rxFrameErr <= 1'b0;
    end else begin
      rxValid    <= rxGoodStop | (rxValid & ~clearMask[STAT_RX_VALID]);
      rxOverrun  <= (rxGoodStop & rxValid) |
                    (rxOverrun & ~clearMask[STAT_RX_OVERRUN]);
      txOverflow <= (txPush & fifoFull) |
                    (txOverflow & ~clearMask[STAT_TX_OVERFLOW]);
      rxFrameErr <= rxBadStop | (rxFrameErr & ~clearMask[STAT_RX_FRAME_ERR]);
    end
  end

  // ---------------------------------------------------------------- readback
  logic [5:0] statusWord;

  always_comb begin
    statusWord                    = '0;
    statusWord[STAT_TX_FULL]      = fifoFull;
    statusWord[STAT_TX_IDLE]      = txIdle;
    statusWord[STAT_RX_VALID]     = rxValid;
    statusWord[STAT_RX_OVERRUN]   = rxOverrun;
    statusWord[STAT_TX_OVERFLOW]  = txOverflow;
    statusWord[STAT_RX_FRAME_ERR] = rxFrameErr;
  end

  // Same-cycle read mux; no side effects.
  // NOTE: the default assignment up front keeps every path driven, so no
  // latch is inferred for offsets or an unselected bus.
  always_comb begin
    busDataOut = 32'd0;
    if (selected) begin
      case (offset)
        OFS_RXDATA:  busDataOut = {24'd0, rxByte};
        OFS_STATUS:  busDataOut = {26'd0, statusWord};
        OFS_DIVISOR: busDataOut = {16'd0, divisor};
        default:     busDataOut = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_uart.sv
// Directed bench for bus_uart: bus register access, TX waveform timing,
// FIFO fill/overflow, RX reception/overrun/glitch/framing and reset abort.
`timescale 1ns/1ps
module tb_bus_uart;

  localparam logic [31:0] ADDR_TX   = 32'h0000_F000;
  localparam logic [31:0] ADDR_RX   = 32'h0000_F004;
  localparam logic [31:0] ADDR_STAT = 32'h0000_F008;
  localparam logic [31:0] ADDR_DIV  = 32'h0000_F00C;

  logic        clk;
  logic        reset;
  logic [31:0] busAddress;
  logic [31:0] busDataIn;
  logic        busWriteEnable;
  logic [31:0] busDataOut;
  logic        selected;
  logic        txd;
  logic        rxd;

  int checkCount = 0;
  int passCount  = 0;
  int cycleCount = 0;
  logic txLog [4096];

  bus_uart #(
    .BASE_ADDR    (32'h0000_F000),
    .CLKS_PER_BIT (16'd868),
    .TX_DEPTH     (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .busAddress     (busAddress),
    .busDataIn      (busDataIn),
    .busWriteEnable (busWriteEnable),
    .busDataOut     (busDataOut),
    .selected       (selected),
    .txd            (txd),
    .rxd            (rxd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter and a per-cycle log of txd (txLog[n] = txd after edge n).
  always @(posedge clk) cycleCount <= cycleCount + 1;
  always @(negedge clk) txLog[cycleCount & 4095] = txd;

  task automatic check(input string tag, input logic [63:0] actual,
                       input logic [63:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    else
      passCount++;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    busAddress     = addr;
    busDataIn      = data;
    busWriteEnable = 1'b1;
    @(posedge clk);
    #1;
    busWriteEnable = 1'b0;
    busAddress     = 32'h0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    busAddress     = addr;
    busWriteEnable = 1'b0;
    #1;
    data = busDataOut;
  endtask

  task automatic waitUntil(input int target);
    while (cycleCount < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare 10*div cycles of txd, starting the edge after startIdx, against
  // an ideal 8N1 frame of the given byte.
  task automatic checkWave(input string tag, input int startIdx, input int div,
                           input logic [7:0] data);
    logic [63:0] obs;
    logic [63:0] exp;
    int n;
    n = 10 * div;
    waitUntil(startIdx + n + 1);
    @(negedge clk);
    #1;
    obs = '0;
    exp = '0;
    for (int c = 0; c < n; c++) begin
      obs[c] = txLog[(startIdx + 1 + c) & 4095];
      if (c < div)          exp[c] = 1'b0;
      else if (c < 9 * div) exp[c] = data[(c - div) / div];
      else                  exp[c] = 1'b1;
    end
    check(tag, obs, exp);
  endtask

  task automatic sendRx(input logic [7:0] data, input int div,
                        input logic stopBit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (div) @(negedge clk);
    end
    rxd = stopBit;
    repeat (div) @(negedge clk);
    rxd = 1'b1;
    repeat (div) @(negedge clk);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int t0;

    reset          = 1'b0;
    rxd            = 1'b1;
    busAddress     = 32'h0;
    busDataIn      = 32'h0;
    busWriteEnable = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("resetTxd", txd, 1'b1);
    busRead(ADDR_STAT, rd); check("resetStatus", rd, 32'h2);
    busRead(ADDR_DIV, rd);  check("resetDivisor", rd, 32'd868);
    busRead(ADDR_RX, rd);   check("resetRxData", rd, 32'h0);
    check("selectedIn", selected, 1'b1);
    busRead(32'h0000_F010, rd);
    check("outsideData", rd, 32'h0);
    check("selectedOut", selected, 1'b0);
    reset = 1'b1;

    // Single frame 0x55 at divisor 4.
    busWrite(ADDR_DIV, 32'd4);
    busRead(ADDR_DIV, rd); check("divisorRw", rd, 32'd4);
    busWrite(ADDR_TX, 32'h55);
    t0 = cycleCount;
    waitUntil(t0 + 40);
    busRead(ADDR_STAT, rd); check("txBusyEnd", rd[1], 1'b0);
    waitUntil(t0 + 41);
    busRead(ADDR_STAT, rd); check("txIdleBack", rd[1], 1'b1);
    checkWave("txWave55", t0, 4, 8'h55);

    // Burst of ten writes: one popped, eight fill the FIFO, tenth dropped.
    busWrite(ADDR_TX, 32'h01);
    t0 = cycleCount;
    for (int k = 2; k <= 9; k++) busWrite(ADDR_TX, 32'(k));
    busRead(ADDR_STAT, rd); check("burstFull", rd, 32'h01);
    busWrite(ADDR_TX, 32'h0A);
    busRead(ADDR_STAT, rd); check("burstOverflow", rd, 32'h11);
    for (int k = 0; k < 9; k++)
      checkWave($sformatf("burstFrame%0d", k), t0 + 40 * k, 4, 8'(k + 1));
    waitUntil(t0 + 361);
    busRead(ADDR_STAT, rd); check("burstDone", rd, 32'h12);
    busWrite(ADDR_STAT, 32'h10);
    busRead(ADDR_STAT, rd); check("overflowClear", rd, 32'h02);

    // Receive, overrun, clear.
    busWrite(ADDR_DIV, 32'd8);
    sendRx(8'hA3, 8, 1'b1);
    busRead(ADDR_STAT, rd); check("rxValid", rd, 32'h06);
    busRead(ADDR_RX, rd);   check("rxByteA3", rd, 32'hA3);
    sendRx(8'h3C, 8, 1'b1);
    busRead(ADDR_STAT, rd); check("rxOverrun", rd, 32'h0E);
    busRead(ADDR_RX, rd);   check("rxByte3C", rd, 32'h3C);
    busWrite(ADDR_STAT, 32'h0C);
    busRead(ADDR_STAT, rd); check("rxClear", rd, 32'h02);

    // Two-clock glitch must be rejected.
    @(negedge clk);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    busRead(ADDR_STAT, rd); check("glitchStatus", rd, 32'h02);
    busRead(ADDR_RX, rd);   check("glitchRxData", rd, 32'h3C);

    // Framing error: byte discarded, rxValid untouched.
    sendRx(8'h5A, 8, 1'b0);
    busRead(ADDR_STAT, rd); check("frameErr", rd, 32'h22);
    busRead(ADDR_RX, rd);   check("frameErrRxData", rd, 32'h3C);
    busWrite(ADDR_STAT, 32'h20);
    busRead(ADDR_STAT, rd); check("frameErrClear", rd, 32'h02);

    // Divisor below the floor runs at two clocks per bit.
    busWrite(ADDR_DIV, 32'd1);
    busRead(ADDR_DIV, rd); check("divisorRaw1", rd, 32'd1);
    busWrite(ADDR_TX, 32'h96);
    t0 = cycleCount;
    checkWave("txWaveMinDiv", t0, 2, 8'h96);

    // Reset in the middle of a start bit.
    busWrite(ADDR_DIV, 32'd4);
    busWrite(ADDR_TX, 32'h0F);
    t0 = cycleCount;
    busWrite(ADDR_TX, 32'hF0);
    waitUntil(t0 + 2);
    check("txMidFrame", txd, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("txdResetEdge", txd, 1'b1);
    busRead(ADDR_STAT, rd); check("resetMidStatus", rd, 32'h02);
    busRead(ADDR_DIV, rd);  check("resetMidDivisor", rd, 32'd868);
    @(negedge clk);
    reset = 1'b1;
    busWrite(ADDR_DIV, 32'd4);
    busWrite(ADDR_TX, 32'hC3);
    t0 = cycleCount;
    checkWave("txAfterReset", t0, 4, 8'hC3);
    waitUntil(t0 + 41);
    busRead(ADDR_STAT, rd); check("idleAfterReset", rd, 32'h02);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
